scoreboard_bypass: RTL

Parametrised scoreboard and forwarding network for the multi-issue integer pipeline. It tracks in-flight destination registers through NUM_STAGES post-issue stages for ISSUE_WIDTH lanes and selects, per read port, the youngest in-flight result or the register file value. It flags operands whose producer is a load whose data is not yet available. It sits between decode/issue and the register file and replaces the fixed 4-port, 3-stage, 2-lane forwarding mux.

---
 rtl/scoreboard_bypass_pkg.sv | 17 +
 rtl/scoreboard_bypass_select.sv | 43 ++++
 rtl/scoreboard_bypass.sv | 86 ++++++++
 3 files changed

// File: rtl/scoreboard_bypass_pkg.sv
// Shared scoreboard types: in-flight destination record and stage index names.
// Register addresses narrower than REG_WIDTH are zero-extended into the record.
package scoreboard_bypass_pkg;

    localparam int REG_WIDTH = 5;

    localparam int STAGE_EXE = 0;
    localparam int STAGE_MEM = 1;
    localparam int STAGE_WB  = 2;

    typedef struct packed {
        logic                 valid;
        logic [REG_WIDTH-1:0] dst;
        logic                 load;
    } sb_entry_t;

endpackage

// File: rtl/scoreboard_bypass_select.sv
// Per-read-port forwarding select: youngest matching in-flight result, else register file.
// Latency: purely combinational.
// Backpressure: none; a load hit before it is forwardable reports operand_ready=0.
module scoreboard_bypass_select
    import scoreboard_bypass_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int NUM_STAGES  = 3,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LOAD_STAGE  = STAGE_MEM
) (
    input  sb_entry_t [NUM_STAGES-1:0][ISSUE_WIDTH-1:0]             entries,
    input  logic      [NUM_STAGES-1:0][ISSUE_WIDTH-1:0][DATA_W-1:0] stage_result,
    input  logic      [ADDR_W-1:0]                                  rd_addr,
    input  logic      [DATA_W-1:0]                                  rf_rdata,
    output logic      [DATA_W-1:0]                                  operand,
    output logic                                                    operand_ready
);

    logic [REG_WIDTH-1:0] addr_ext;

    assign addr_ext = REG_WIDTH'(rd_addr);

    // Scan oldest-to-youngest so the last match (lowest stage, highest lane) wins.
    always_comb begin
        operand       = rf_rdata;
        operand_ready = 1'b1;
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
            for (int l = 0; l < ISSUE_WIDTH; l++) begin
                if (entries[s][l].valid && (entries[s][l].dst == addr_ext)) begin
                    operand       = stage_result[s][l];
                    operand_ready = !(entries[s][l].load && (s < LOAD_STAGE));
                end
            end
        end
        if (rd_addr == '0) begin
            operand       = '0;
            operand_ready = 1'b1;
        end
    end

endmodule

// File: rtl/scoreboard_bypass.sv
// Scoreboard of in-flight destinations plus per-port operand forwarding network.
// Latency: entries shift on advance (one edge); operand/ready/stall are combinational.
// Backpressure: issue_stall asserts when a consumed operand waits on an unforwardable load.
module scoreboard_bypass
    import scoreboard_bypass_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int NUM_STAGES  = 3,
    parameter int NUM_READ    = 4,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = REG_WIDTH,
    parameter int LOAD_STAGE  = STAGE_MEM
) (
    input  logic                                             clk,
    input  logic                                             resetn,
    input  logic                                             advance,
    input  logic                                             flush,
    input  logic [ISSUE_WIDTH-1:0]                           issue_valid,
    input  logic [ISSUE_WIDTH-1:0]                           issue_wen,
    input  logic [ISSUE_WIDTH-1:0]                           issue_load,
    input  logic [ISSUE_WIDTH-1:0][ADDR_W-1:0]               issue_dst,
    input  logic [NUM_STAGES-1:0][ISSUE_WIDTH-1:0][DATA_W-1:0] stage_result,
    input  logic [NUM_READ-1:0][ADDR_W-1:0]                  rd_addr,
    input  logic [NUM_READ-1:0][DATA_W-1:0]                  rf_rdata,
    input  logic [NUM_READ-1:0]                              rd_used,
    output logic [NUM_READ-1:0][DATA_W-1:0]                  operand,
    output logic [NUM_READ-1:0]                              operand_ready,
    output logic                                             issue_stall
);

    sb_entry_t [NUM_STAGES-1:0][ISSUE_WIDTH-1:0] entries;
    logic      [NUM_READ-1:0][DATA_W-1:0]        sel_operand;
    logic      [NUM_READ-1:0]                    sel_ready;

    // Writes to r0 are never tracked so a zero-register read can never be forwarded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entries <= '0;
        end else if (flush) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                for (int l = 0; l < ISSUE_WIDTH; l++) begin
                    entries[s][l].valid <= 1'b0;
                end
            end
        end else if (advance) begin
            for (int s = NUM_STAGES - 1; s >= 1; s--) begin
                entries[s] <= entries[s-1];
            end
            for (int l = 0; l < ISSUE_WIDTH; l++) begin
                entries[0][l].valid <= issue_valid[l] & issue_wen[l] & (issue_dst[l] != '0);
                entries[0][l].dst   <= REG_WIDTH'(issue_dst[l]);
                entries[0][l].load  <= issue_load[l];
            end
        end
    end

    for (genvar r = 0; r < NUM_READ; r++) begin : g_port
        scoreboard_bypass_select #(
            .ISSUE_WIDTH (ISSUE_WIDTH),
            .NUM_STAGES  (NUM_STAGES),
            .DATA_W      (DATA_W),
            .ADDR_W      (ADDR_W),
            .LOAD_STAGE  (LOAD_STAGE)
        ) u_select (
            .entries       (entries),
            .stage_result  (stage_result),
            .rd_addr       (rd_addr[r]),
            .rf_rdata      (rf_rdata[r]),
            .operand       (sel_operand[r]),
            .operand_ready (sel_ready[r])
        );
    end

    // While held in reset the network is transparent, including reads of r0.
    always_comb begin
        if (!resetn) begin
            operand       = rf_rdata;
            operand_ready = '1;
        end else begin
            operand       = sel_operand;
            operand_ready = sel_ready;
        end
        issue_stall = |(~operand_ready & rd_used);
    end

endmodule
